// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: round-robin warp issue with per-warp pending/halted tracking.
// A grant is held until accepted; the next grant is chosen in the accepting cycle.
module warp_issue_scheduler #(
   parameter int NUM_WARPS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_WARPS-1:0] warp_en,
   input  logic                 issue_ready,
   output logic                 issue_valid,
   output logic [4:0]           issue_warp,
   output logic                 issue_last,
   input  logic                 dec_valid,
   input  logic [4:0]           dec_warp,
   input  logic [7:0]           dec_flags,
   input  logic                 dec_err,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_warp,
   output logic [NUM_WARPS-1:0] pending,
   output logic [NUM_WARPS-1:0] halted,
   output logic [31:0]          issue_count
);
   localparam logic [NUM_WARPS-1:0] one_w = 1;
   typedef enum logic {IDLE, OFFER} state_t;
   state_t state, state_n;
   logic [NUM_WARPS-1:0] en_q, elig, mask, set_p, clr_p, set_h, fall;
   logic [4:0] rr_ptr, base, sel, idx;
   logic found, last, hs, load, dec_clr, unused_flags;
   assign unused_flags = ^dec_flags;
   assign issue_valid = state == OFFER;
   assign hs = issue_valid && issue_ready;
   assign elig = warp_en & ~pending & ~halted;
   // on a handshake the search restarts after the warp being accepted, which is excluded
   assign base = issue_valid ? issue_warp : rr_ptr;
   assign mask = issue_valid ? elig & ~(one_w << issue_warp) : elig;
   assign load = (!issue_valid || hs) && found;
   assign dec_clr = (dec_valid && !dec_flags[2] && !dec_flags[4]) || dec_err;
   assign set_p = hs ? one_w << issue_warp : '0;
   assign clr_p = (dec_clr ? one_w << dec_warp : '0) | (wb_valid ? one_w << wb_warp : '0);
   assign set_h = dec_err ? one_w << dec_warp : '0;
   assign fall = en_q & ~warp_en;
   always_comb begin
      found = 1'b0;
      sel = '0;
      idx = '0;
      last = 1'b1;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = base + 5'(i + 1);
         if (!found && mask[idx]) begin
            found = 1'b1;
            sel = idx;
         end
      end
      for (int i = 0; i < NUM_WARPS; i++)
         if (mask[i] && i > int'(sel)) last = 1'b0;
   end
   always_comb begin
      state_n = state;
      if (!issue_valid || hs) state_n = found ? OFFER : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_warp  <= '0;
         issue_last  <= 1'b0;
         rr_ptr      <= '1;
         pending     <= '0;
         halted      <= '0;
         issue_count <= '0;
         en_q        <= '0;
      end else begin
         if (load) begin
            issue_warp <= sel;
            issue_last <= last;
         end
         if (hs) rr_ptr <= issue_warp;
         pending     <= (pending & ~clr_p) | set_p;
         halted      <= (halted & ~fall) | set_h;
         issue_count <= issue_count + 32'(hs);
         en_q        <= warp_en;
      end
   end
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb_warp_issue_scheduler: scenario tasks with a grant scoreboard for warp_issue_scheduler.
module tb_warp_issue_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] warp_en = '0;
   logic        issue_ready = 1'b0;
   logic        issue_valid;
   logic [4:0]  issue_warp;
   logic        issue_last;
   logic        dec_valid = 1'b0;
   logic [4:0]  dec_warp = '0;
   logic [7:0]  dec_flags = '0;
   logic        dec_err = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_warp = '0;
   logic [31:0] pending, halted, issue_count;
   int checks = 0, failures = 0, hs_cnt = 0;
   logic [5:0] exp_q[$], got_q[$];
   bit dec_on = 1'b0;
   logic [7:0] br_flags = 8'h29;

   warp_issue_scheduler dut (
      .clk(clk), .rst_n(rst_n), .warp_en(warp_en), .issue_ready(issue_ready),
      .issue_valid(issue_valid), .issue_warp(issue_warp), .issue_last(issue_last),
      .dec_valid(dec_valid), .dec_warp(dec_warp), .dec_flags(dec_flags), .dec_err(dec_err),
      .wb_valid(wb_valid), .wb_warp(wb_warp), .pending(pending), .halted(halted),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   // one cycle; logs the handshake completed at this edge and plays the decoder one cycle later
   task automatic step();
      logic h;
      logic [5:0] g;
      h = issue_valid && issue_ready;
      g = {issue_last, issue_warp};
      @(posedge clk); #1;
      dec_valid = dec_on && h;
      dec_warp = g[4:0];
      dec_flags = (g[4:0] == 5'd1) ? br_flags : 8'h29;
      if (h) begin
         got_q.push_back(g);
         hs_cnt++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; warp_en = '0; issue_ready = 1'b0; dec_valid = 1'b0; dec_err = 1'b0;
      wb_valid = 1'b0; dec_on = 1'b0; br_flags = 8'h29;
      got_q.delete(); exp_q.delete(); hs_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({issue_valid, issue_warp, issue_last} !== 7'd0) begin
         failures++; $display("FAIL reset_issue got v=%b w=%0d l=%b exp 0", issue_valid, issue_warp, issue_last);
      end
      checks++;
      if ({pending, halted, issue_count} !== 96'd0) begin
         failures++; $display("FAIL reset_state got p=%h h=%h c=%h exp 0", pending, halted, issue_count);
      end
      do_reset();
      repeat (3) step();
      checks++;
      if (issue_valid !== 1'b0) begin
         failures++; $display("FAIL no_enable_idle got v=%b exp 0", issue_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [5:0] g, e;
      do_reset();
      warp_en = 32'hF; issue_ready = 1'b1; dec_on = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back({(k % 4) == 3, 5'(k % 4)});
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 5'd0) begin
         failures++; $display("FAIL first_grant got v=%b w=%0d exp v=1 w=0", issue_valid, issue_warp);
      end
      for (int k = 0; k < 20 && got_q.size() < 8; k++) step();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got_q.size() == 0) begin
            failures++; $display("FAIL rr_grant%0d got none exp %h", k, exp_q[0]);
         end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
               failures++; $display("FAIL rr_grant%0d got last=%b w=%0d exp last=%b w=%0d", k, g[5], g[4:0], e[5], e[4:0]);
            end
         end
      end
      checks++;
      if (issue_count !== 32'(hs_cnt)) begin
         failures++; $display("FAIL rr_count got %0d exp %0d", issue_count, hs_cnt);
      end
   endtask

   task automatic test_stall();
      logic [5:0] g;
      do_reset();
      warp_en = 32'h5;
      step();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (issue_valid !== 1'b1 || issue_warp !== 5'd0 || issue_last !== 1'b0) begin
            failures++; $display("FAIL stall_hold%0d got v=%b w=%0d l=%b exp v=1 w=0 l=0", k, issue_valid, issue_warp, issue_last);
         end
         if (k == 1) warp_en = 32'h4;
         step();
      end
      issue_ready = 1'b1;
      exp_q.push_back({1'b0, 5'd0});
      step();
      issue_ready = 1'b0;
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 5'd2 || issue_last !== 1'b1) begin
         failures++; $display("FAIL stall_next got v=%b w=%0d l=%b exp v=1 w=2 l=1", issue_valid, issue_warp, issue_last);
      end
      g = got_q.size() ? got_q.pop_front() : 6'h3F;
      checks++;
      if (g !== exp_q.pop_front() || pending !== 32'h1) begin
         failures++; $display("FAIL stall_hs got grant=%h pend=%h exp grant=00 pend=1", g, pending);
      end
   endtask

   task automatic test_branch();
      int c1;
      logic [5:0] g;
      do_reset();
      warp_en = 32'h3; issue_ready = 1'b1; dec_on = 1'b1; br_flags = 8'h3D;
      repeat (12) step();
      c1 = 0;
      foreach (got_q[i]) if (got_q[i][4:0] == 5'd1) c1++;
      checks++;
      if (c1 != 1 || got_q.size() < 4) begin
         failures++; $display("FAIL branch_skip got w1_grants=%0d total=%0d exp 1 and >=4", c1, got_q.size());
      end
      warp_en = 32'h2;
      repeat (4) step();
      got_q.delete();
      checks++;
      if (pending !== 32'h2 || issue_valid !== 1'b0) begin
         failures++; $display("FAIL branch_wait got pend=%h v=%b exp pend=2 v=0", pending, issue_valid);
      end
      wb_valid = 1'b1; wb_warp = 5'd1;
      exp_q.push_back({1'b1, 5'd1});
      step();
      wb_valid = 1'b0;
      checks++;
      if (pending !== 32'h0 || issue_valid !== 1'b0) begin
         failures++; $display("FAIL branch_wb got pend=%h v=%b exp pend=0 v=0", pending, issue_valid);
      end
      step();
      step();
      g = got_q.size() ? got_q.pop_front() : 6'h3F;
      checks++;
      if (g !== exp_q.pop_front()) begin
         failures++; $display("FAIL branch_regrant got %h exp 21", g);
      end
   endtask

   task automatic test_halt();
      int c2;
      do_reset();
      warp_en = 32'h5; issue_ready = 1'b1; dec_on = 1'b1;
      dec_err = 1'b1; dec_warp = 5'd2;
      step();
      dec_err = 1'b0;
      checks++;
      if (halted !== 32'h4) begin
         failures++; $display("FAIL halt_set got %h exp 4", halted);
      end
      repeat (12) step();
      c2 = 0;
      foreach (got_q[i]) if (got_q[i][4:0] == 5'd2) c2++;
      checks++;
      if (c2 != 0 || got_q.size() == 0) begin
         failures++; $display("FAIL halt_skip got w2_grants=%0d total=%0d exp 0 and >0", c2, got_q.size());
      end
      warp_en = 32'h1;
      step();
      warp_en = 32'h5;
      checks++;
      if (halted !== 32'h0) begin
         failures++; $display("FAIL halt_clear got %h exp 0", halted);
      end
      got_q.delete();
      repeat (10) step();
      c2 = 0;
      foreach (got_q[i]) if (got_q[i][4:0] == 5'd2) c2++;
      checks++;
      if (c2 == 0) begin
         failures++; $display("FAIL halt_regrant got w2_grants=0 exp >0");
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      warp_en = 32'h1; issue_ready = 1'b1;
      step();
      step();
      issue_ready = 1'b0;
      checks++;
      if (pending !== 32'h1) begin
         failures++; $display("FAIL same_setup got pend=%h exp 1", pending);
      end
      dec_valid = 1'b1; dec_warp = 5'd0; dec_flags = 8'h29; wb_valid = 1'b1; wb_warp = 5'd0;
      step();
      wb_valid = 1'b0;
      checks++;
      if (pending !== 32'h0 || halted !== 32'h0) begin
         failures++; $display("FAIL same_clear got pend=%h halt=%h exp 0 0", pending, halted);
      end
      wb_valid = 1'b1;
      step();
      wb_valid = 1'b0;
      checks++;
      if (pending !== 32'h0 || issue_valid !== 1'b1) begin
         failures++; $display("FAIL same_ignore got pend=%h v=%b exp pend=0 v=1", pending, issue_valid);
      end
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      dec_err = 1'b1; dec_warp = 5'd0; wb_valid = 1'b1; wb_warp = 5'd0;
      step();
      dec_err = 1'b0; wb_valid = 1'b0;
      checks++;
      if (halted !== 32'h1 || pending !== 32'h0) begin
         failures++; $display("FAIL err_wb got halt=%h pend=%h exp 1 0", halted, pending);
      end
      checks++;
      if (issue_count !== 32'(hs_cnt) || hs_cnt != 2) begin
         failures++; $display("FAIL same_count got %0d exp 2 (logged %0d)", issue_count, hs_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      warp_en = 32'hF; issue_ready = 1'b1; dec_on = 1'b1;
      repeat (6) step();
      issue_ready = 1'b0; dec_on = 1'b0;
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_warp === 5'd0) begin
         failures++; $display("FAIL mid_pre got v=%b w=%0d exp v=1 w!=0", issue_valid, issue_warp);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({issue_valid, issue_warp, issue_last} !== 7'd0 || {pending, halted, issue_count} !== 96'd0) begin
         failures++; $display("FAIL mid_reset got v=%b w=%0d l=%b p=%h h=%h c=%h exp 0", issue_valid, issue_warp, issue_last, pending, halted, issue_count);
      end
      dec_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 5'd0 || issue_count !== 32'd0) begin
         failures++; $display("FAIL mid_first got v=%b w=%0d c=%0d exp v=1 w=0 c=0", issue_valid, issue_warp, issue_count);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_stall();
      test_branch();
      test_halt();
      test_same_cycle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
